// File: rtl/tick_timer_pkg.sv
// Shared definitions for the tick_timer block.
// Holds the timer state encoding and the timebase select encodings used to
// index the TICK_EN bus (bit 0 = 1 us, bit 1 = 10 us, bit 2 = 1 ms, bit 3 = 1 s).
package tick_timer_pkg;

    // Timer FSM states. A prefix keeps them distinct from the EXPIRED port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    // Timebase select encodings (index into TICK_EN).
    localparam logic [1:0] TB_1US  = 2'd0;
    localparam logic [1:0] TB_10US = 2'd1;
    localparam logic [1:0] TB_1MS  = 2'd2;
    localparam logic [1:0] TB_1S   = 2'd3;

endpackage

// File: rtl/tick_gap_monitor.sv
// Tick-gap supervisor for the selected timebase.
// Counts clk cycles since the last accepted tick (or since the counter was
// cleared) and flags when a further tick-less cycle would exceed the
// allowed gap for the selected timebase.
// Ports:
//   clk, nrst : clock, asynchronous active-low reset
//   clr       : clear the gap counter (timer start/stop)
//   run       : timer is counting; the counter only advances while high
//   tick      : selected tick enable for this cycle
//   sel       : latched timebase select, picks the gap limit
//   gap_err   : combinational, high when this tick-less cycle hits the limit
module tick_gap_monitor
    import tick_timer_pkg::*;
#(
    parameter int                  GapWidth  = 22,
    parameter logic [GapWidth-1:0] GapLimit0 = 22'd4,
    parameter logic [GapWidth-1:0] GapLimit1 = 22'd40,
    parameter logic [GapWidth-1:0] GapLimit2 = 22'd4000,
    parameter logic [GapWidth-1:0] GapLimit3 = 22'd4000000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr,
    input  logic       run,
    input  logic       tick,
    input  logic [1:0] sel,
    output logic       gap_err
);

    localparam logic [GapWidth-1:0] GAP_ONE = GapWidth'(1);
    localparam logic [GapWidth-1:0] GAP_MAX = {GapWidth{1'b1}};

    logic [GapWidth-1:0] gap_cnt_r;
    logic [GapWidth-1:0] limit_s;

    // Select the allowed gap for the latched timebase.
    always_comb begin
        limit_s = GapLimit3;
        case (sel)
            TB_1US:  limit_s = GapLimit0;
            TB_10US: limit_s = GapLimit1;
            TB_1MS:  limit_s = GapLimit2;
            TB_1S:   limit_s = GapLimit3;
            default: limit_s = GapLimit3;
        endcase
    end

    // The counter holds limit-1 on the cycle the error is raised, so the
    // error fires on the limit-th consecutive tick-less cycle.
    assign gap_err = run && !tick && (gap_cnt_r == (limit_s - GAP_ONE));

    // Gap counter: cleared by clr or a tick, saturating increment otherwise.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gap_cnt_r <= '0;
        end else if (clr) begin
            gap_cnt_r <= '0;
        end else if (run) begin
            if (tick) begin
                gap_cnt_r <= '0;
            end else if (gap_cnt_r != GAP_MAX) begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
        end else begin
            gap_cnt_r <= '0;
        end
    end

endmodule

// File: rtl/tick_timer.sv
// Programmable down-counting timer driven by periodic tick enables.
// A START latches the timebase select and the delay, then each selected
// tick decrements the remaining count until it expires. A stalled
// timebase (no tick within the allowed gap) moves the timer to an error
// state that holds the remaining count for debug.
// Ports:
//   clk, nrst  : 2 MHz clock, asynchronous active-low reset
//   TICK_EN    : one-clk tick enables [0]=1us [1]=10us [2]=1ms [3]=1s
//   TB_SEL     : timebase select, latched on START
//   LOAD_VAL   : delay in ticks, latched on START
//   START/STOP : one-clk start/restart and abort requests (STOP wins)
//   BUSY       : high while running
//   DONE       : one-clk pulse on expiry
//   EXPIRED    : level, high after expiry until next START/STOP
//   TICK_ERR   : level, high after a tick stall until next START/STOP
//   CNT_REMAIN : remaining ticks
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int                  CntWidth  = 16,
    parameter int                  GapWidth  = 22,
    parameter logic [GapWidth-1:0] GapLimit0 = 22'd4,
    parameter logic [GapWidth-1:0] GapLimit1 = 22'd40,
    parameter logic [GapWidth-1:0] GapLimit2 = 22'd4000,
    parameter logic [GapWidth-1:0] GapLimit3 = 22'd4000000
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [3:0]          TICK_EN,
    input  logic [1:0]          TB_SEL,
    input  logic [CntWidth-1:0] LOAD_VAL,
    input  logic                START,
    input  logic                STOP,
    output logic                BUSY,
    output logic                DONE,
    output logic                EXPIRED,
    output logic                TICK_ERR,
    output logic [CntWidth-1:0] CNT_REMAIN
);

    localparam logic [CntWidth-1:0] CNT_ONE = CntWidth'(1);

    state_t     state_r;
    logic [1:0] tb_sel_r;
    logic       tick_sel_s;
    logic       gap_err_s;
    logic       gap_clr_s;
    logic       run_s;

    assign tick_sel_s = TICK_EN[tb_sel_r];
    assign run_s      = (state_r == ST_RUN);
    assign gap_clr_s  = START || STOP;

    tick_gap_monitor #(
        .GapWidth  (GapWidth),
        .GapLimit0 (GapLimit0),
        .GapLimit1 (GapLimit1),
        .GapLimit2 (GapLimit2),
        .GapLimit3 (GapLimit3)
    ) u_gap_mon (
        .clk     (clk),
        .nrst    (nrst),
        .clr     (gap_clr_s),
        .run     (run_s),
        .tick    (tick_sel_s),
        .sel     (tb_sel_r),
        .gap_err (gap_err_s)
    );

    // Timer FSM with the remaining-tick counter and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r    <= ST_IDLE;
            tb_sel_r   <= TB_1US;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            EXPIRED    <= 1'b0;
            TICK_ERR   <= 1'b0;
            CNT_REMAIN <= '0;
        end else begin
            DONE <= 1'b0;
            if (STOP) begin
                state_r    <= ST_IDLE;
                BUSY       <= 1'b0;
                EXPIRED    <= 1'b0;
                TICK_ERR   <= 1'b0;
                CNT_REMAIN <= '0;
            end else if (START) begin
                // Any tick in this cycle is ignored; counting starts next cycle.
                tb_sel_r   <= TB_SEL;
                CNT_REMAIN <= LOAD_VAL;
                TICK_ERR   <= 1'b0;
                if (LOAD_VAL == '0) begin
                    state_r <= ST_EXPIRED;
                    BUSY    <= 1'b0;
                    EXPIRED <= 1'b1;
                    DONE    <= 1'b1;
                end else begin
                    state_r <= ST_RUN;
                    BUSY    <= 1'b1;
                    EXPIRED <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_RUN: begin
                        if (tick_sel_s) begin
                            if (CNT_REMAIN != '0) begin
                                CNT_REMAIN <= CNT_REMAIN - CNT_ONE;
                            end else begin
                                CNT_REMAIN <= CNT_REMAIN;
                            end
                            if (CNT_REMAIN <= CNT_ONE) begin
                                state_r <= ST_EXPIRED;
                                BUSY    <= 1'b0;
                                EXPIRED <= 1'b1;
                                DONE    <= 1'b1;
                            end else begin
                                state_r <= ST_RUN;
                            end
                        end else if (gap_err_s) begin
                            // CNT_REMAIN is frozen for debug.
                            state_r  <= ST_ERR;
                            BUSY     <= 1'b0;
                            TICK_ERR <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                    ST_IDLE, ST_EXPIRED, ST_ERR: begin
                        state_r <= state_r;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: a vector table, directed multi-cycle
// sequences and a randomized run, all compared every cycle against a
// cycle-stamp reference model of the timer rules.
module tb_tick_timer;
    import tick_timer_pkg::*;

    logic        clk;
    logic        nrst;
    logic [3:0]  tick_en;
    logic [1:0]  tb_sel;
    logic [15:0] load_val;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        expired;
    logic        tick_err;
    logic [15:0] cnt_remain;

    int n_pass  = 0;
    int n_total = 0;

    tick_timer dut (
        .clk        (clk),
        .nrst       (nrst),
        .TICK_EN    (tick_en),
        .TB_SEL     (tb_sel),
        .LOAD_VAL   (load_val),
        .START      (start),
        .STOP       (stop),
        .BUSY       (busy),
        .DONE       (done),
        .EXPIRED    (expired),
        .TICK_ERR   (tick_err),
        .CNT_REMAIN (cnt_remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 run, 2 expired, 3 error.
    // A stall is detected by comparing the current cycle stamp with the
    // stamp of the last start or accepted tick.
    int m_mode, m_cnt, m_sel, m_last, m_done, cyc;
    int lim [4] = '{4, 40, 4000, 4000000};

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_sel = 0; m_last = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (stop) begin
            m_mode = 0; m_cnt = 0;
        end else if (start) begin
            m_sel  = int'(tb_sel);
            m_cnt  = int'(load_val);
            m_last = cyc;
            if (load_val == 16'd0) begin m_mode = 2; m_done = 1; end
            else m_mode = 1;
        end else if (m_mode == 1) begin
            if (tick_en[m_sel]) begin
                m_cnt  = m_cnt - 1;
                m_last = cyc;
                if (m_cnt == 0) begin m_mode = 2; m_done = 1; end
            end else if (cyc - m_last >= lim[m_sel]) begin
                m_mode = 3;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic check_model();
        check("model_busy",    32'(busy),       32'(m_mode == 1));
        check("model_done",    32'(done),       32'(m_done));
        check("model_expired", 32'(expired),    32'(m_mode == 2));
        check("model_tickerr", 32'(tick_err),   32'(m_mode == 3));
        check("model_cnt",     32'(cnt_remain), 32'(m_cnt));
    endtask

    // Advance one clock edge, update the model, sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle_in();
        start = 1'b0; stop = 1'b0; tick_en = 4'd0;
    endtask

    task automatic do_start(input logic [1:0] s, input logic [15:0] l);
        tb_sel = s; load_val = l; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    typedef struct {
        logic        start, stop;
        logic [1:0]  sel;
        logic [15:0] load;
        logic [3:0]  tick;
        logic        busy, done, expd, err;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt [16];
    int   dcount;

    initial begin
        //            st    sp    sel   load   tick     busy  done  exp   err   cnt
        vt[0]  = '{1'b1, 1'b0, 2'd0, 16'd2, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        vt[1]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        vt[2]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[5]  = '{1'b1, 1'b1, 2'd0, 16'd5, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[6]  = '{1'b1, 1'b0, 2'd0, 16'd1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vt[7]  = '{1'b1, 1'b0, 2'd0, 16'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3};
        vt[8]  = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
        vt[9]  = '{1'b0, 1'b1, 2'd0, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[10] = '{1'b0, 1'b1, 2'd0, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
        vt[11] = '{1'b1, 1'b0, 2'd2, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vt[12] = '{1'b1, 1'b0, 2'd1, 16'd0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
        vt[13] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
        vt[14] = '{1'b1, 1'b0, 2'd3, 16'd1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1};
        vt[15] = '{1'b0, 1'b0, 2'd0, 16'd0, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};

        cyc = 0;
        model_reset();
        idle_in();
        tb_sel = 2'd0; load_val = 16'd0;
        nrst = 1'b0;
        #12;
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(done),       32'd0);
        check("rst_expired", 32'(expired),    32'd0);
        check("rst_tickerr", 32'(tick_err),   32'd0);
        check("rst_cnt",     32'(cnt_remain), 32'd0);
        nrst = 1'b1;
        step();

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            start = vt[i].start; stop = vt[i].stop; tb_sel = vt[i].sel;
            load_val = vt[i].load; tick_en = vt[i].tick;
            step();
            check($sformatf("vec%0d_busy", i), 32'(busy),       32'(vt[i].busy));
            check($sformatf("vec%0d_done", i), 32'(done),       32'(vt[i].done));
            check($sformatf("vec%0d_exp", i),  32'(expired),    32'(vt[i].expd));
            check($sformatf("vec%0d_err", i),  32'(tick_err),   32'(vt[i].err));
            check($sformatf("vec%0d_cnt", i),  32'(cnt_remain), 32'(vt[i].cnt));
        end
        idle_in();

        // 10 us timebase, 3 ticks 20 clk apart, other bits toggling randomly.
        do_start(TB_10US, 16'd3);
        check("seq1_start_cnt", 32'(cnt_remain), 32'd3);
        dcount = 0;
        for (int c = 1; c <= 60; c++) begin
            tick_en = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       (c % 20) == 0, $urandom_range(0, 1) == 1};
            step();
            if (done) dcount++;
            if (c == 20) check("seq1_cnt_t1", 32'(cnt_remain), 32'd2);
            if (c == 40) check("seq1_cnt_t2", 32'(cnt_remain), 32'd1);
            if (c == 60) begin
                check("seq1_done",    32'(done),       32'd1);
                check("seq1_cnt_end", 32'(cnt_remain), 32'd0);
                check("seq1_busy",    32'(busy),       32'd0);
            end
        end
        idle_in();
        step();
        if (done) dcount++;
        check("seq1_done_count", 32'(dcount),   32'd1);
        check("seq1_expired",    32'(expired),  32'd1);
        check("seq1_tickerr",    32'(tick_err), 32'd0);

        // Zero-length delay: expiry on the START edge, never busy.
        do_start(TB_1MS, 16'd0);
        check("seq2_done",    32'(done),    32'd1);
        check("seq2_expired", 32'(expired), 32'd1);
        check("seq2_busy",    32'(busy),    32'd0);
        step();
        check("seq2_done_off", 32'(done), 32'd0);

        // Stalled 1 us timebase: error on the 4th clk after START.
        do_start(TB_1US, 16'd5);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 3) check("seq3_no_err_yet", 32'(tick_err), 32'd0);
        end
        check("seq3_tickerr", 32'(tick_err),   32'd1);
        check("seq3_busy",    32'(busy),       32'd0);
        check("seq3_cnt",     32'(cnt_remain), 32'd5);
        do_start(TB_10US, 16'd4);
        check("seq3_err_clr", 32'(tick_err), 32'd0);

        // Four ticks then STOP; then START+STOP together.
        do_start(TB_10US, 16'd10);
        dcount = 0;
        for (int c = 1; c <= 20; c++) begin
            tick_en = ((c % 5) == 0) ? 4'b0010 : 4'b0000;
            step();
            if (done) dcount++;
        end
        check("seq4_cnt_before_stop", 32'(cnt_remain), 32'd6);
        idle_in();
        stop = 1'b1;
        step();
        stop = 1'b0;
        if (done) dcount++;
        check("seq4_stop_busy", 32'(busy),       32'd0);
        check("seq4_stop_cnt",  32'(cnt_remain), 32'd0);
        check("seq4_no_done",   32'(dcount),     32'd0);
        start = 1'b1; stop = 1'b1; load_val = 16'd7;
        step();
        idle_in();
        check("seq4_both_busy", 32'(busy),       32'd0);
        check("seq4_both_cnt",  32'(cnt_remain), 32'd0);

        // Restart mid-run with a shorter delay.
        do_start(TB_10US, 16'd8);
        for (int c = 1; c <= 15; c++) begin
            tick_en = ((c % 5) == 0) ? 4'b0010 : 4'b0000;
            step();
        end
        idle_in();
        do_start(TB_10US, 16'd2);
        check("seq5_restart_cnt", 32'(cnt_remain), 32'd2);
        for (int c = 1; c <= 10; c++) begin
            tick_en = ((c % 5) == 0) ? 4'b0010 : 4'b0000;
            step();
            if (c == 5)  check("seq5_cnt_mid", 32'(cnt_remain), 32'd1);
        end
        check("seq5_done", 32'(done), 32'd1);
        idle_in();

        // Asynchronous reset mid-run, coincident with a tick.
        do_start(TB_10US, 16'd10);
        for (int c = 1; c <= 6; c++) begin
            tick_en = ((c % 3) == 0) ? 4'b0010 : 4'b0000;
            step();
        end
        tick_en = 4'b0010;
        #2;
        nrst = 1'b0;
        #1;
        model_reset();
        check("seq6_rst_busy", 32'(busy),       32'd0);
        check("seq6_rst_done", 32'(done),       32'd0);
        check("seq6_rst_exp",  32'(expired),    32'd0);
        check("seq6_rst_cnt",  32'(cnt_remain), 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle_in();
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick_en = 4'b0010;
            step();
            if (done) dcount++;
        end
        check("seq6_no_done", 32'(dcount), 32'd0);
        idle_in();

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            tb_sel   = 2'($urandom_range(0, 3));
            load_val = 16'($urandom_range(0, 5));
            tick_en  = {$urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0};
            step();
        end
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable down-counting timer that consumes the periodic one-cycle tick enables (1 µs, 10 µs, 1 ms, 1 s) produced by the clock-enable generator. It is the receiving end of that tick interface. It times delays for power-sequencing and debounce logic in units of a selected timebase. It also supervises the selected tick stream and flags a stalled timebase.

## Interface
- CntWidth, 16, width of LOAD_VAL / CNT_REMAIN
- GapWidth, 22, width of tick-gap counter
- GapLimit0, 22'd4, max clk cycles allowed between 1 µs ticks
- GapLimit1, 22'd40, max clk cycles allowed between 10 µs ticks
- GapLimit2, 22'd4000, max clk cycles allowed between 1 ms ticks
- GapLimit3, 22'd4000000, max clk cycles allowed between 1 s ticks
- clk  in  1  2 MHz system clock
- nrst  in  1  reset, asynchronous, active-low
- TICK_EN  in  4  one-clk tick enables; [0]=1 µs, [1]=10 µs, [2]=1 ms, [3]=1 s
- TB_SEL  in  2  timebase select, indexes TICK_EN; latched on START
- LOAD_VAL  in  CntWidth  delay in ticks; latched on START
- START  in  1  one-clk start/restart request
- STOP  in  1  one-clk abort request
- BUSY  out  1  high in RUN
- DONE  out  1  one-clk pulse on expiry
- EXPIRED  out  1  level, high in EXPIRED until next START/STOP
- TICK_ERR  out  1  level, high in ERR until next START/STOP
- CNT_REMAIN  out  CntWidth  remaining ticks

## Operation
- States: IDLE, RUN, EXPIRED, ERR. Reset state is IDLE.
- START in any state: latch TB_SEL and LOAD_VAL, clear the gap counter, go to RUN. A START in RUN is a restart with the new values.
- START with LOAD_VAL=0: go directly to EXPIRED and pulse DONE. RUN is not entered.
- STOP in RUN, EXPIRED or ERR: go to IDLE and clear CNT_REMAIN. No DONE is issued.
- START and STOP in the same cycle: STOP wins.
- RUN, selected tick high: CNT_REMAIN decrements by 1 and the gap counter clears.
  - If CNT_REMAIN was 1, go to EXPIRED and pulse DONE.
- RUN, selected tick low: the gap counter increments.
  - If the gap counter equals GapLimit[sel]-1, go to ERR. CNT_REMAIN holds its value, for debug.
- A tick in the same cycle as START is ignored. Counting starts from the next cycle.
- Non-selected TICK_EN bits are ignored.
- CNT_REMAIN never wraps; it saturates at 0.
- Gap counter arithmetic is unsigned, GapWidth bits, and saturates.

## Timing
- All outputs are registered. Reset values: BUSY=0, DONE=0, EXPIRED=0, TICK_ERR=0, CNT_REMAIN=0.
- START sampled at edge N → BUSY=1 and CNT_REMAIN=LOAD_VAL from edge N.
- Final tick sampled at edge M → at edge M: DONE=1 for exactly one cycle, EXPIRED=1, BUSY=0, CNT_REMAIN=0.
- LOAD_VAL=0 START at edge N → at edge N: DONE=1, EXPIRED=1.
- ERR entry: TICK_ERR=1 and BUSY=0 at the edge where gap counter = GapLimit[sel]-1 is sampled with no tick.
- nrst asserted mid-operation: all state and outputs return to reset values immediately (asynchronous). No DONE is issued.
- Throughput: one START can be accepted every cycle.

## Structure
- Shared package tick_timer_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2, ERR=2'd3
  - timebase encodings TB_1US/TB_10US/TB_1MS/TB_1S = 0..3
- Sub-module tick_gap_monitor holds the gap counter and the limit mux.
  - Inputs: clk, nrst, clr, run, tick, sel.
  - Output: gap_err, combinational.
- The top level holds the FSM, the remaining-tick counter and the output registers.

## Test plan
- TB_SEL=1, LOAD_VAL=3, TICK_EN[1] pulsed every 20 clk, START at cycle 0 → CNT_REMAIN steps 3→2→1→0 on each tick; DONE is a single pulse on the 3rd tick edge (cycle 60); EXPIRED=1 afterward; TICK_ERR=0.
- LOAD_VAL=0, START → DONE=1 and EXPIRED=1 on the START edge; BUSY never 1.
- TB_SEL=0, LOAD_VAL=5, TICK_EN held 0 after START → TICK_ERR=1 at the 4th clk after START; BUSY=0; CNT_REMAIN=5; the next START clears TICK_ERR.
- RUN with LOAD_VAL=10 for 4 ticks, then STOP → IDLE, CNT_REMAIN=0, no DONE. A second run with START+STOP in the same cycle → stays IDLE.
- Restart: LOAD_VAL=8 running, START with LOAD_VAL=2 after 3 ticks → CNT_REMAIN=2; DONE after 2 further ticks.
- nrst pulsed low mid-RUN coincident with a tick → all outputs 0 immediately; no DONE after release.
